apb_intc: RTL and testbench
===========================

# apb_intc

APB-mapped interrupt controller that collects up to 16 peripheral interrupt lines (the HPET `int_o`, UART, GPIO, …), latches them as pending, and presents one masked, priority-arbitrated request to the CPU. Software claims the highest-priority source through a CLAIM read and releases it through a COMPLETE write. It sits on the same APB segment as the timer and drives the CPU external-interrupt input.

## Interface
- `NUM_IRQ`, default 8: number of sources, legal range 1..16. Source 0 is the HPET.
- `apb_pclk`  in  1  sole clock; all state on rising edge.
- `apb_prstn`  in  1  reset, asynchronous, active-low.
- `apb_psel`  in  1  APB select.
- `apb_paddr`  in  4  byte address: 0x0 PEND, 0x4 MASK, 0x8 EDGE, 0xC CLAIM/COMPLETE.
- `apb_pwrite`  in  1  1 = write.
- `apb_penable`  in  1  APB access phase.
- `apb_pwdata`  in  32  write data.
- `apb_prdata`  out  32  read data.
- `irq_i`  in  NUM_IRQ  interrupt sources, active-high.
- `int_o`  out  1  request to CPU.

## Operation
- Access qualifiers: `we = psel & penable & pwrite`, `re = psel & penable & ~pwrite`. There are no wait states. Each read side-effect fires once, in the single access-phase cycle.
- Registers (bits `[NUM_IRQ-1:0]` live; upper bits read 0 and ignore writes):
  - PEND: pending flags. Write-1-to-clear acts on edge sources only.
  - MASK: 1 = enabled. Read/write.
  - EDGE: 1 = rising-edge source, 0 = level source. Read/write.
  - CLAIM: read returns `{valid, 27'b0, id[3:0]}`. Write to 0xC is COMPLETE, with `pwdata[3:0]` as the id.
- `s[i]` is the sampled input (see Configuration). `p[i]` is the previous value of `s[i]`.
- Edge source pending: set when `s & ~p`. Cleared by PEND W1C or by a CLAIM of that id. If a set and a clear land in the same cycle, the set wins.
- Level source pending: `pend[i] <= s[i]` every cycle. W1C and CLAIM do not clear it.
- In-service register `isr`:
  - A CLAIM sets `isr[id]`.
  - A COMPLETE with `id < NUM_IRQ` clears `isr[id]`.
  - A COMPLETE for an id that is not in service, or with `id >= NUM_IRQ`, has no effect.
- Eligible set: `elig = pend & mask & ~isr`.
- Arbitration: the lowest eligible index wins.
  - A CLAIM with `elig != 0` returns valid = 1 and the winning id.
  - A CLAIM with `elig == 0` returns 0 and changes nothing.
- `int_o = |elig`. It is combinational from registers only, with no input-to-output path.
- Changing MASK never alters PEND. A masked source keeps latching and raises `int_o` as soon as it is unmasked.
- Switching a bit from edge to level: that pending bit tracks `s` from the next cycle.
- `apb_prdata` is the register value during `re` and 0 otherwise.

## Timing
- Reset (asynchronous, while `apb_prstn` = 0):
  - PEND, MASK, EDGE, `isr`, synchronizer and `p` flops clear to 0.
  - `int_o` = 0 and `apb_prdata` = 0.
  - Reset mid-claim discards all in-service state.
- Input latency with INTC_SYNC_EN, when `irq_i` is first sampled high at edge k:
  - `s` is high after edge k+1.
  - `pend` is set at edge k+2.
  - `int_o` is high after edge k+2.
- Input latency without INTC_SYNC_EN: `pend` is set at edge k and `int_o` is high after edge k.
- CLAIM read in access cycle at edge c:
  - `apb_prdata` is valid in that cycle.
  - `isr` and pending-clear take effect at edge c.
  - `int_o` reflects the claim from edge c.
- COMPLETE write at edge c: `isr` clears at edge c. A source still pending re-raises `int_o` after edge c.
- A PEND W1C and a CLAIM of the same bit in the same cycle both clear. A rising edge in that cycle overrides both.

## Configuration
- `INTC_SYNC_EN` defined:
  - `s` comes through a two-flop synchronizer per source.
  - Required for sources from other clock domains.
- `INTC_SYNC_EN` undefined:
  - `s = irq_i` directly. Only the `p` flop is kept.
  - Saves two cycles of latency. Legal only when all sources are `apb_pclk`-synchronous, as the HPET is.

## Test plan
- Reset then read all four addresses -> all read 0x0000_0000, `int_o` = 0. Assert reset mid-stream with bits set -> all clear immediately.
- EDGE=0x1, MASK=0x1, pulse `irq_i[0]` for 1 cycle -> PEND=0x1, `int_o` = 1 with the latency above. CLAIM -> 0x8000_0000. PEND=0, `int_o` = 0. COMPLETE 0 -> `isr` cleared, `int_o` stays 0.
- EDGE=0xFF, MASK=0xFF, raise sources 5 and 2 together -> CLAIM returns 0x8000_0002, then 0x8000_0005, then 0x0000_0000. `int_o` drops after the second claim.
- Level source 3 held high, MASK=0x08, EDGE=0 -> CLAIM returns 0x8000_0003, `int_o` = 0 while in service. COMPLETE 3 with input still high -> `int_o` = 1 next cycle. W1C PEND=0x08 -> no change.
- MASK=0, rising edge on source 1 -> PEND=0x2, `int_o` = 0. Write MASK=0x2 -> `int_o` = 1. In the same cycle as a W1C of bit 1, apply a new rising edge -> PEND bit 1 remains 1.
- COMPLETE id 9 with NUM_IRQ = 8, and COMPLETE of a non-claimed id -> no state change. Run the suite with and without `INTC_SYNC_EN` -> latency difference of exactly 2 cycles.

Source files
------------

// File: rtl/apb_intc.sv
// APB interrupt controller: pending latch, mask, edge/level select, lowest-index claim/complete.
// Define INTC_SYNC_EN to pass each irq_i through a two-flop synchronizer before edge/level detection.
module apb_intc #(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic               apb_pclk,
  input  logic               apb_prstn,
  input  logic               apb_psel,
  input  logic [3:0]         apb_paddr,
  input  logic               apb_pwrite,
  input  logic               apb_penable,
  input  logic [31:0]        apb_pwdata,
  output logic [31:0]        apb_prdata,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               int_o
);

  localparam logic [3:0] ADDR_PEND  = 4'h0;
  localparam logic [3:0] ADDR_MASK  = 4'h4;
  localparam logic [3:0] ADDR_EDGE  = 4'h8;
  localparam logic [3:0] ADDR_CLAIM = 4'hC;

  logic               we, re;
  logic [NUM_IRQ-1:0] pend, mask, edge_q, isr;
  logic [NUM_IRQ-1:0] s, p;
  logic [NUM_IRQ-1:0] elig, w1c, claim_oh, cmpl_oh;
  logic               claim_valid, claim_go, cmpl_go;
  logic [3:0]         claim_id;
  logic               unused_pwdata;

  assign we = apb_psel & apb_penable & apb_pwrite;
  assign re = apb_psel & apb_penable & ~apb_pwrite;
  assign unused_pwdata = ^apb_pwdata;

`ifdef INTC_SYNC_EN
  logic [NUM_IRQ-1:0] sync_q, s_q;

  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      sync_q <= '0;
      s_q    <= '0;
    end else begin
      sync_q <= irq_i;
      s_q    <= sync_q;
    end
  end

  assign s = s_q;
`else
  assign s = irq_i;
`endif

  assign elig        = pend & mask & ~isr;
  assign claim_valid = |elig;
  assign int_o       = claim_valid;
  assign claim_go    = re & (apb_paddr == ADDR_CLAIM) & claim_valid;
  assign cmpl_go     = we & (apb_paddr == ADDR_CLAIM);
  assign w1c         = (we && apb_paddr == ADDR_PEND) ? apb_pwdata[NUM_IRQ-1:0] : '0;

  // Scan downward so the lowest eligible index is the last one assigned.
  always_comb begin
    claim_id = '0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (elig[i-1]) claim_id = 4'(i - 1);
    end
  end

  // Complete ids at or above NUM_IRQ match no bit and so fall through harmlessly.
  always_comb begin
    claim_oh = '0;
    cmpl_oh  = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      claim_oh[i] = claim_go & (claim_id == 4'(i));
      cmpl_oh[i]  = cmpl_go & (apb_pwdata[3:0] == 4'(i));
    end
  end

  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      p      <= '0;
      pend   <= '0;
      mask   <= '0;
      edge_q <= '0;
      isr    <= '0;
    end else begin
      p    <= s;
      // Edge bits: clears applied first so a same-cycle rising edge still sets.
      pend <= (edge_q & ((pend & ~w1c & ~claim_oh) | (s & ~p))) | (~edge_q & s);
      isr  <= (isr | claim_oh) & ~cmpl_oh;
      if (we && apb_paddr == ADDR_MASK) mask   <= apb_pwdata[NUM_IRQ-1:0];
      if (we && apb_paddr == ADDR_EDGE) edge_q <= apb_pwdata[NUM_IRQ-1:0];
    end
  end

  always_comb begin
    apb_prdata = '0;
    if (re) begin
      case (apb_paddr)
        ADDR_PEND:  apb_prdata = 32'(pend);
        ADDR_MASK:  apb_prdata = 32'(mask);
        ADDR_EDGE:  apb_prdata = 32'(edge_q);
        ADDR_CLAIM: apb_prdata = {claim_valid, 27'b0, claim_id};
        default:    apb_prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_intc.sv
// Scoreboard bench for apb_intc: stimulus queues expected read data / int_o, a monitor compares.
module tb_apb_intc;

`ifdef INTC_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [3:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic [7:0]  irq = '0;
  logic        int_o;
  logic        probe = 1'b0;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    logic        intv;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  apb_intc #(.NUM_IRQ(8)) dut (
    .apb_pclk    (clk),
    .apb_prstn   (rst_n),
    .apb_psel    (psel),
    .apb_paddr   (paddr),
    .apb_pwrite  (pwrite),
    .apb_penable (penable),
    .apb_pwdata  (pwdata),
    .apb_prdata  (prdata),
    .irq_i       (irq),
    .int_o       (int_o)
  );

  always #5 clk = ~clk;

  // Monitor: pops one expectation for every read access phase or int_o probe.
  always @(negedge clk) begin
    if ((psel && penable && !pwrite) || probe) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_output: no expectation queued (prdata=%h int_o=%b)", prdata, int_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_rd) begin
          checks++;
          if (prdata !== e.data) begin
            errors++;
            $display("FAIL %s prdata: got %h expected %h", e.name, prdata, e.data);
          end
        end
        checks++;
        if (int_o !== e.intv) begin
          errors++;
          $display("FAIL %s int_o: got %b expected %b", e.name, int_o, e.intv);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] ed, input logic ei, input string nm);
    exp_t e;
    e.is_rd = 1'b1; e.data = ed; e.intv = ei; e.name = nm;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    exp_q.push_back(e);
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic probe_int(input logic ei, input string nm);
    exp_t e;
    e.is_rd = 1'b0; e.data = '0; e.intv = ei; e.name = nm;
    exp_q.push_back(e);
    probe = 1'b1;
    @(negedge clk); #1;
    probe = 1'b0;
  endtask

  // PEND write whose access edge coincides with the first detected rising edge of irq[1].
  task automatic w1c_with_rise(input logic [31:0] d);
    if (LAT == 2) begin
      @(posedge clk); #1;
      irq[1] = 1'b1;
    end
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h0; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    if (LAT == 0) irq[1] = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reads while held in reset, then after release
    rd(4'h0, 32'h0, 1'b0, "rst_pend");
    rd(4'h4, 32'h0, 1'b0, "rst_mask");
    rd(4'h8, 32'h0, 1'b0, "rst_edge");
    rd(4'hC, 32'h0, 1'b0, "rst_claim");
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd(4'h0, 32'h0, 1'b0, "post_pend");
    rd(4'h4, 32'h0, 1'b0, "post_mask");
    rd(4'h8, 32'h0, 1'b0, "post_edge");
    rd(4'hC, 32'h0, 1'b0, "post_claim");

    // Edge source 0: latency, claim, complete
    wr(4'h8, 32'h1);
    wr(4'h4, 32'h1);
    @(posedge clk); #1;
    irq[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      if (j == 0) irq[0] = 1'b0;
      probe_int(j >= LAT, $sformatf("latency_%0d", j));
    end
    rd(4'h0, 32'h1, 1'b1, "e0_pend");
    rd(4'hC, 32'h8000_0000, 1'b1, "e0_claim");
    rd(4'h0, 32'h0, 1'b0, "e0_pend_after_claim");
    wr(4'hC, 32'h0);
    rd(4'hC, 32'h0, 1'b0, "e0_claim_empty");

    // Two simultaneous edges: lowest index first
    wr(4'h8, 32'hFF);
    wr(4'h4, 32'hFF);
    irq[5] = 1'b1; irq[2] = 1'b1;
    tick(4);
    rd(4'hC, 32'h8000_0002, 1'b1, "prio_claim_2");
    rd(4'hC, 32'h8000_0005, 1'b1, "prio_claim_5");
    rd(4'hC, 32'h0, 1'b0, "prio_claim_none");
    irq[5] = 1'b0; irq[2] = 1'b0;
    wr(4'hC, 32'h2);
    wr(4'hC, 32'h5);
    rd(4'h4, 32'hFF, 1'b0, "mask_readback");
    rd(4'h8, 32'hFF, 1'b0, "edge_readback");

    // Level source 3
    wr(4'h8, 32'h0);
    wr(4'h4, 32'h08);
    irq[3] = 1'b1;
    tick(4);
    rd(4'h0, 32'h08, 1'b1, "lvl_pend");
    rd(4'hC, 32'h8000_0003, 1'b1, "lvl_claim");
    rd(4'h0, 32'h08, 1'b0, "lvl_in_service");
    wr(4'h0, 32'h08);
    rd(4'h0, 32'h08, 1'b0, "lvl_w1c_ignored");
    wr(4'hC, 32'h3);
    probe_int(1'b1, "lvl_complete_reraise");
    wr(4'h0, 32'h08);
    rd(4'h0, 32'h08, 1'b1, "lvl_w1c_after_complete");
    irq[3] = 1'b0;
    tick(4);
    rd(4'h0, 32'h0, 1'b0, "lvl_follows_input");

    // Masked edge source 1, unmask, W1C racing a new edge
    wr(4'h4, 32'h0);
    wr(4'h8, 32'h02);
    irq[1] = 1'b1;
    tick(4);
    rd(4'h0, 32'h02, 1'b0, "masked_pend");
    wr(4'h4, 32'h02);
    rd(4'h0, 32'h02, 1'b1, "unmasked_int");
    irq[1] = 1'b0;
    tick(4);
    w1c_with_rise(32'h02);
    tick(4);
    rd(4'h0, 32'h02, 1'b1, "set_beats_w1c");
    irq[1] = 1'b0;
    tick(4);
    wr(4'h0, 32'h02);
    rd(4'h0, 32'h0, 1'b0, "edge_w1c_clears");

    // Out-of-range and non-claimed completes
    wr(4'h8, 32'h01);
    wr(4'h4, 32'h01);
    irq[0] = 1'b1; tick(1); irq[0] = 1'b0;
    tick(4);
    rd(4'hC, 32'h8000_0000, 1'b1, "oor_claim0");
    irq[0] = 1'b1; tick(1); irq[0] = 1'b0;
    tick(4);
    rd(4'h0, 32'h01, 1'b0, "oor_pend_blocked");
    wr(4'hC, 32'h9);
    probe_int(1'b0, "complete_9");
    wr(4'hC, 32'h8);
    probe_int(1'b0, "complete_8");
    wr(4'hC, 32'h2);
    probe_int(1'b0, "complete_unclaimed");
    wr(4'hC, 32'h0);
    probe_int(1'b1, "complete_0");
    wr(4'h4, 32'hFFFF_FF00);
    rd(4'h4, 32'h0, 1'b0, "mask_upper_ignored");
    wr(4'h4, 32'h1);
    rd(4'hC, 32'h8000_0000, 1'b1, "reclaim0");

    // Reset mid-stream with a claim outstanding
    wr(4'h8, 32'h03);
    wr(4'h4, 32'h03);
    irq[0] = 1'b1; irq[1] = 1'b1; tick(1); irq[0] = 1'b0; irq[1] = 1'b0;
    tick(4);
    rd(4'h0, 32'h03, 1'b1, "pre_reset_pend");
    @(posedge clk); #1;
    rst_n = 1'b0;
    probe_int(1'b0, "reset_int_immediate");
    rd(4'h0, 32'h0, 1'b0, "reset_pend");
    rd(4'h4, 32'h0, 1'b0, "reset_mask");
    rd(4'h8, 32'h0, 1'b0, "reset_edge");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr(4'h8, 32'h01);
    wr(4'h4, 32'h01);
    irq[0] = 1'b1; tick(1); irq[0] = 1'b0;
    tick(4);
    rd(4'hC, 32'h8000_0000, 1'b1, "isr_discarded_by_reset");

    tick(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
